// File: rtl/word16_to_nibble_serializer.sv
// Serializes a 16-bit word into 1..4 nibbles with a valid/ready handshake on both sides.
// Nibble order is set by LSB_FIRST; a new word can be accepted on the last-nibble handshake.
module word16_to_nibble_serializer #(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [15:0] in_word,
  input  logic [1:0]  in_cnt,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  out_nib,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_reg;
  logic [15:0] word_reg;
  logic [1:0]  k_reg;
  logic [1:0]  last_k_reg;   // N-1; in_cnt=0 (N=4) wraps naturally to 3

  logic [1:0]  k_next;
  logic [1:0]  last_k_next;
  logic [1:0]  idx_int;
  logic        last_int;
  logic        send;
  logic        out_fire;
  logic        in_fire;
  logic [3:0]  nib_arr [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib_arr[gi] = word_reg[4*gi +: 4];
    end
  endgenerate

  // MSB-first walks the index downward: 3-k is the bitwise inverse of k.
  assign idx_int     = (LSB_FIRST != 0) ? k_reg : ~k_reg;
  assign last_int    = (k_reg == last_k_reg);
  assign k_next      = k_reg + 2'd1;
  assign last_k_next = in_cnt - 2'd1;

  assign send     = (state_reg == SEND);
  assign out_fire = send & out_ready;
  assign in_ready = ~send | (out_fire & last_int);
  assign in_fire  = in_valid & in_ready;

  assign out_valid = send;
  assign busy      = send;
  assign out_idx   = send ? idx_int : 2'd0;
  assign out_nib   = send ? nib_arr[idx_int] : 4'd0;
  assign out_last  = send & last_int;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg  <= IDLE;
      word_reg   <= 16'd0;
      k_reg      <= 2'd0;
      last_k_reg <= 2'd3;
    end else if (in_fire) begin
      // Covers both the idle accept and the zero-bubble reload on the last handshake.
      state_reg  <= SEND;
      word_reg   <= in_word;
      k_reg      <= 2'd0;
      last_k_reg <= last_k_next;
    end else if (out_fire) begin
      if (last_int) begin
        state_reg <= IDLE;
        k_reg     <= 2'd0;
      end else begin
        k_reg <= k_next;
      end
    end
  end

endmodule

// File: tb/tb_word16_to_nibble_serializer.sv
// Directed bench for word16_to_nibble_serializer: one LSB-first and one MSB-first instance.
module tb_word16_to_nibble_serializer;

  logic        CLK;
  logic        Reset_n;
  logic [15:0] in_word;
  logic [1:0]  in_cnt;
  logic        in_valid_l, in_valid_m;
  logic        out_ready;

  logic        in_ready_l, out_last_l, out_valid_l, busy_l;
  logic [3:0]  out_nib_l;
  logic [1:0]  out_idx_l;
  logic        in_ready_m, out_last_m, out_valid_m, busy_m;
  logic [3:0]  out_nib_m;
  logic [1:0]  out_idx_m;

  int vec_cnt;
  int err_cnt;

  word16_to_nibble_serializer #(.LSB_FIRST(1)) u_lsb (
    .CLK(CLK), .Reset_n(Reset_n), .in_word(in_word), .in_cnt(in_cnt),
    .in_valid(in_valid_l), .in_ready(in_ready_l), .out_nib(out_nib_l),
    .out_idx(out_idx_l), .out_last(out_last_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .busy(busy_l)
  );

  word16_to_nibble_serializer #(.LSB_FIRST(0)) u_msb (
    .CLK(CLK), .Reset_n(Reset_n), .in_word(in_word), .in_cnt(in_cnt),
    .in_valid(in_valid_m), .in_ready(in_ready_m), .out_nib(out_nib_m),
    .out_idx(out_idx_m), .out_last(out_last_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .busy(busy_m)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Checks the output bundle of the selected instance (msb=0 -> LSB-first unit).
  task automatic chk_out(input bit msb, input string tag, input logic v,
                         input logic [3:0] nib, input logic [1:0] idx, input logic last);
    if (!msb) begin
      check({tag, ".valid"}, 32'(out_valid_l), 32'(v));
      check({tag, ".nib"},   32'(out_nib_l),   32'(nib));
      check({tag, ".idx"},   32'(out_idx_l),   32'(idx));
      check({tag, ".last"},  32'(out_last_l),  32'(last));
    end else begin
      check({tag, ".valid"}, 32'(out_valid_m), 32'(v));
      check({tag, ".nib"},   32'(out_nib_m),   32'(nib));
      check({tag, ".idx"},   32'(out_idx_m),   32'(idx));
      check({tag, ".last"},  32'(out_last_m),  32'(last));
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] exp_nib [4];
  logic [1:0] exp_idx [4];
  logic       exp_last[4];
  int         k;
  int         cyc;

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    Reset_n    = 1'b0;
    in_word    = 16'd0;
    in_cnt     = 2'd0;
    in_valid_l = 1'b0;
    in_valid_m = 1'b0;
    out_ready  = 1'b0;
    #2;
    chk_out(0, "rst_l", 1'b0, 4'h0, 2'd0, 1'b0);
    check("rst_l.busy",     32'(busy_l),     32'd0);
    check("rst_l.in_ready", 32'(in_ready_l), 32'd1);
    check("rst_m.in_ready", 32'(in_ready_m), 32'd1);
    #10;
    Reset_n = 1'b1;
    step();

    // A5C3, N=4, LSB-first: 3,C,5,A on idx 0..3
    in_word = 16'hA5C3; in_cnt = 2'd0; in_valid_l = 1'b1; out_ready = 1'b1;
    #1;
    check("t1.in_ready", 32'(in_ready_l), 32'd1);
    step();
    in_valid_l = 1'b0;
    exp_nib = '{4'h3, 4'hC, 4'h5, 4'hA};
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      chk_out(0, $sformatf("t1.n%0d", i), 1'b1, exp_nib[i], exp_idx[i], exp_last[i]);
      step();
    end
    chk_out(0, "t1.done", 1'b0, 4'h0, 2'd0, 1'b0);
    check("t1.busy", 32'(busy_l), 32'd0);

    // 1234, N=2, MSB-first: 1 (idx3), 2 (idx2)
    in_word = 16'h1234; in_cnt = 2'd2; in_valid_m = 1'b1;
    step();
    in_valid_m = 1'b0;
    chk_out(1, "t2.n0", 1'b1, 4'h1, 2'd3, 1'b0);
    step();
    chk_out(1, "t2.n1", 1'b1, 4'h2, 2'd2, 1'b1);
    step();
    chk_out(1, "t2.done", 1'b0, 4'h0, 2'd0, 1'b0);
    check("t2.busy", 32'(busy_m), 32'd0);

    // BEEF, LSB-first, out_ready pattern 1,0,0 repeating: F,E,E,B with stalls
    in_word = 16'hBEEF; in_cnt = 2'd0; in_valid_l = 1'b1; out_ready = 1'b0;
    step();
    in_valid_l = 1'b0;
    exp_nib = '{4'hF, 4'hE, 4'hE, 4'hB};
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 20) begin
      out_ready = (cyc % 3 == 0);
      #1;
      chk_out(0, $sformatf("t3.c%0d", cyc), 1'b1, exp_nib[k], 2'(k), k == 3);
      if (out_ready) k++;
      cyc++;
      step();
    end
    check("t3.all_sent", 32'(k), 32'd4);
    chk_out(0, "t3.done", 1'b0, 4'h0, 2'd0, 1'b0);

    // Back-to-back N=1 words 0001, 0002 with in_valid held high
    out_ready = 1'b1;
    in_word = 16'h0001; in_cnt = 2'd1; in_valid_l = 1'b1;
    step();
    in_word = 16'h0002;
    #1;
    chk_out(0, "t4.w1", 1'b1, 4'h1, 2'd0, 1'b1);
    check("t4.in_ready1", 32'(in_ready_l), 32'd1);
    step();
    in_valid_l = 1'b0;
    chk_out(0, "t4.w2", 1'b1, 4'h2, 2'd0, 1'b1);
    check("t4.in_ready2", 32'(in_ready_l), 32'd1);
    step();
    chk_out(0, "t4.done", 1'b0, 4'h0, 2'd0, 1'b0);

    // CAFE reset after 2nd nibble, then 00F0 serializes 0,F,0,0
    in_word = 16'hCAFE; in_cnt = 2'd0; in_valid_l = 1'b1;
    step();
    in_valid_l = 1'b0;
    chk_out(0, "t5.n0", 1'b1, 4'hE, 2'd0, 1'b0);
    step();
    chk_out(0, "t5.n1", 1'b1, 4'hF, 2'd1, 1'b0);
    step();
    Reset_n = 1'b0;
    #1;
    chk_out(0, "t5.rst", 1'b0, 4'h0, 2'd0, 1'b0);
    check("t5.rst_busy",     32'(busy_l),     32'd0);
    check("t5.rst_in_ready", 32'(in_ready_l), 32'd1);
    step();
    Reset_n = 1'b1;
    step();
    check("t5.post_in_ready", 32'(in_ready_l), 32'd1);
    in_word = 16'h00F0; in_cnt = 2'd0; in_valid_l = 1'b1;
    step();
    in_valid_l = 1'b0;
    exp_nib = '{4'h0, 4'hF, 4'h0, 4'h0};
    for (int i = 0; i < 4; i++) begin
      chk_out(0, $sformatf("t5.m%0d", i), 1'b1, exp_nib[i], 2'(i), i == 3);
      step();
    end

    // in_valid while busy with out_ready=0: new word ignored
    out_ready = 1'b0;
    in_word = 16'h1357; in_cnt = 2'd0; in_valid_l = 1'b1;
    step();
    in_word = 16'hFFFF; in_cnt = 2'd1;
    #1;
    check("t6.in_ready", 32'(in_ready_l), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out(0, $sformatf("t6.hold%0d", i), 1'b1, 4'h7, 2'd0, 1'b0);
    end
    in_valid_l = 1'b0;
    out_ready = 1'b1;
    exp_nib = '{4'h7, 4'h5, 4'h3, 4'h1};
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_out(0, $sformatf("t6.n%0d", i), 1'b1, exp_nib[i], 2'(i), i == 3);
      step();
    end
    chk_out(0, "t6.done", 1'b0, 4'h0, 2'd0, 1'b0);

    // MSB-first N=3 on ABCD: A (idx3), B (idx2), C (idx1)
    in_word = 16'hABCD; in_cnt = 2'd3; in_valid_m = 1'b1;
    step();
    in_valid_m = 1'b0;
    exp_nib = '{4'hA, 4'hB, 4'hC, 4'h0};
    for (int i = 0; i < 3; i++) begin
      chk_out(1, $sformatf("t7.n%0d", i), 1'b1, exp_nib[i], 2'(3 - i), i == 2);
      step();
    end
    chk_out(1, "t7.done", 1'b0, 4'h0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/word16_to_nibble_serializer.md
WORD16_TO_NIBBLE_SERIALIZER -- requirements
Module: word16_to_nibble_serializer

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1; 1 = nibble [3:0] sent first, 0 = nibble [15:12] sent first.
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_word, input, 16, word to serialize.
REQ-005 SHALL have port in_cnt, input, 2, number of nibbles to send; 1..3 literal, 0 = 4.
REQ-006 SHALL have port in_valid, input, 1, in_word/in_cnt valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts a word this cycle.
REQ-008 SHALL have port out_nib, output, 4, current nibble.
REQ-009 SHALL have port out_idx, output, 2, position of out_nib within the word (0 = bits [3:0]).
REQ-010 SHALL have port out_last, output, 1, out_nib is the final nibble of the word.
REQ-011 SHALL have port out_valid, output, 1, out_nib/out_idx/out_last valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the nibble.
REQ-013 SHALL have port busy, output, 1, a word is held (state SEND).

Function
REQ-014 SHALL implement two states: IDLE (no word held) and SEND (word held, nibbles pending).
REQ-015 SHALL accept a word when in_valid && in_ready at the clock edge: latch in_word, latch nibble total N (in_cnt, with 0 mapped to 4), clear the sent counter to 0, and enter SEND.
REQ-016 SHALL assert in_ready combinationally when the state is IDLE, or when out_valid && out_ready && out_last (back-to-back accept; out_ready-to-in_ready path permitted).
REQ-017 SHALL assert out_valid exactly while in SEND; no combinational path from in_valid to out_valid; first nibble is available 1 cycle after acceptance.
REQ-018 SHALL, with LSB_FIRST=1, send the k-th nibble (k=0..N-1) from out_idx=k; with LSB_FIRST=0, send it from out_idx=3-k. For N<4, LSB_FIRST=1 sends the low N nibbles and LSB_FIRST=0 sends the high N nibbles.
REQ-019 SHALL drive out_nib = held_word[4*out_idx+3 : 4*out_idx].
REQ-020 SHALL assert out_last when k = N-1.
REQ-021 SHALL advance k by 1 only on a cycle with out_valid && out_ready; out_nib, out_idx, out_last and the held word SHALL stay stable while out_valid && !out_ready.
REQ-022 SHALL, on the out_last handshake, return to IDLE, or reload and remain in SEND if a new word is accepted in the same cycle (zero-bubble); sustained throughput is N nibbles per N cycles.
REQ-023 SHALL ignore in_word, in_cnt and in_valid while in_ready=0; a held word is never overwritten mid-transfer.
REQ-024 SHALL drive out_nib, out_idx and out_last to 0 whenever out_valid=0.
REQ-025 SHALL keep the counter 2-bit, with no wrap past N-1: the terminal handshake reloads or idles.

Reset
REQ-026 SHALL, on Reset_n low and asynchronously, force state IDLE, held word 0, k 0 and N 4, so that out_valid=0, busy=0, out_nib=0, out_idx=0, out_last=0, in_ready=1.
REQ-027 SHALL, on reset mid-transfer, discard the remaining nibbles; the first edge after deassertion behaves as IDLE.

Verification
REQ-028 SHALL cover: LSB_FIRST=1, in_word=16'hA5C3, in_cnt=0, out_ready=1 -> nibbles 3,C,5,A on out_idx 0,1,2,3 in 4 consecutive cycles, out_last on the 4th only.
REQ-029 SHALL cover: LSB_FIRST=0, in_word=16'h1234, in_cnt=2 -> nibbles 1 (idx 3), 2 (idx 2), out_last on the 2nd; then idle with busy=0.
REQ-030 SHALL cover: out_ready toggled 1,0,0,1,... during 16'hBEEF (LSB_FIRST=1) -> outputs held stable on stall cycles; sequence F,E,E,B; no nibble lost or repeated.
REQ-031 SHALL cover: in_valid held high with words 16'h0001 then 16'h0002, in_cnt=1, out_ready=1 -> in_ready high on each out_last cycle; output 1,2 on consecutive cycles with no bubble.
REQ-032 SHALL cover: Reset_n pulsed low after the 2nd nibble of 16'hCAFE -> out_valid=0 immediately (asynchronous); after release in_ready=1; a new word 16'h00F0 (in_cnt=0) serializes as 0,F,0,0.
REQ-033 SHALL cover: in_valid asserted while busy and out_ready=0 -> word ignored, the held word's nibbles unchanged.
